// File: rtl/sd_photo_pkg.sv
// Shared types and constants for the SD-card photo save/load scheduler.
package sd_photo_pkg;

  localparam logic [31:0] BASE_SEC          = 32'd73744;
  localparam int unsigned SECTORS_PER_PHOTO = 1200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_e;

  // First sector of a photo slot. The production stride of 1200 sectors is
  // built from shifts (1024+128+32+16); any other stride uses a multiply.
  function automatic logic [31:0] slot_to_sector(input logic [3:0] slot,
                                                 input logic [31:0] base,
                                                 input int unsigned spp);
    logic [31:0] s;
    s = {28'd0, slot};
    if (spp == 32'd1200)
      return base + (s << 10) + (s << 7) + (s << 5) + (s << 4);
    else
      return base + s * spp;
  endfunction

endpackage

// File: rtl/sd_pace_timer.sv
// Loadable down-counter shared by the inter-sector gap and the busy timeout.
// A start pulse loads a cycle count; expired rises once that many cycles
// have elapsed and stays high until the next start.
module sd_pace_timer #(
  parameter int unsigned WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  // Next count: reload on start, otherwise count down and stop at zero.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (start) begin
      armed_d = 1'b1;
      cnt_d   = (load_val == '0) ? '0 : load_val - 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign expired = armed_q && (cnt_q == '0);

endmodule

// File: rtl/sd_photo_scheduler.sv
// Arbitrates the single SD sector controller between photo save (write) and
// photo load (read), issuing paced per-sector start pulses and tracking
// completion and timeout of each transfer.
module sd_photo_scheduler
  import sd_photo_pkg::*;
#(
  parameter logic [31:0] BASE_SEC          = sd_photo_pkg::BASE_SEC,
  parameter int unsigned SECTORS_PER_PHOTO = sd_photo_pkg::SECTORS_PER_PHOTO,
  parameter int unsigned GAP_CYCLES        = 50000,
  parameter int unsigned TIMEOUT_CYCLES    = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        save_req,
  input  logic        load_req,
  input  logic [3:0]  slot_in,
  input  logic        wr_busy,
  input  logic        rd_busy,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  output logic        save_active,
  output logic        load_active,
  output logic [10:0] sector_idx,
  output logic        xfer_done,
  output logic        xfer_err
);

  localparam int unsigned MAX_T  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned TW     = $clog2(MAX_T + 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES);
  localparam logic [TW-1:0] TMO_LD = TW'(TIMEOUT_CYCLES);
  localparam logic [10:0]   SPP    = 11'(SECTORS_PER_PHOTO);

  state_e      state_q, state_d;
  logic        save_pend_q, save_pend_d;
  logic        load_pend_q, load_pend_d;
  logic [3:0]  save_slot_q, save_slot_d;
  logic [3:0]  load_slot_q, load_slot_d;
  logic        mode_load_q, mode_load_d;
  logic [31:0] sec_addr_q, sec_addr_d;
  logic [10:0] sector_idx_q, sector_idx_d;
  logic        wr_start_q, wr_start_d;
  logic        rd_start_q, rd_start_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        save_active_q, save_active_d;
  logic        load_active_q, load_active_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic          sel_busy;
  logic          issue;
  logic          fail;
  logic          timer_start;
  logic [TW-1:0] timer_load;
  logic          timer_expired;

  sd_pace_timer #(
    .WIDTH(TW)
  ) u_pace_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (timer_start),
    .load_val(timer_load),
    .expired (timer_expired)
  );

  // Next-state, datapath and request latching for the transfer sequencer.
  always_comb begin
    state_d       = state_q;
    save_pend_d   = save_pend_q;
    load_pend_d   = load_pend_q;
    save_slot_d   = save_slot_q;
    load_slot_d   = load_slot_q;
    mode_load_d   = mode_load_q;
    sec_addr_d    = sec_addr_q;
    sector_idx_d  = sector_idx_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    save_active_d = save_active_q;
    load_active_d = load_active_q;
    wr_start_d    = 1'b0;
    rd_start_d    = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    timer_start   = 1'b0;
    timer_load    = GAP_LD;
    issue         = 1'b0;
    fail          = 1'b0;
    sel_busy      = mode_load_q ? rd_busy : wr_busy;

    unique case (state_q)
      ST_IDLE: begin
        if (save_pend_q) begin
          save_pend_d   = 1'b0;
          mode_load_d   = 1'b0;
          sec_addr_d    = slot_to_sector(save_slot_q, BASE_SEC, SECTORS_PER_PHOTO);
          sector_idx_d  = '0;
          save_active_d = 1'b1;
          state_d       = ST_ISSUE;
        end else if (load_pend_q) begin
          load_pend_d   = 1'b0;
          mode_load_d   = 1'b1;
          sec_addr_d    = slot_to_sector(load_slot_q, BASE_SEC, SECTORS_PER_PHOTO);
          sector_idx_d  = '0;
          load_active_d = 1'b1;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!sel_busy) issue = 1'b1;
      end
      ST_WAIT_HI: begin
        if (timer_expired)  fail    = 1'b1;
        else if (sel_busy)  state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!sel_busy) begin
          sec_addr_d = sec_addr_q + 32'd1;
          if (sector_idx_q != SPP) sector_idx_d = sector_idx_q + 11'd1;
          if (sector_idx_q >= SPP - 11'd1) begin
            state_d = ST_DONE;
          end else begin
            timer_start = 1'b1;
            timer_load  = GAP_LD;
            state_d     = ST_GAP;
          end
        end else if (timer_expired) begin
          fail = 1'b1;
        end
      end
      ST_GAP: begin
        // Issuing straight from GAP keeps the busy-fall to start distance
        // at GAP_CYCLES+1; ISSUE is only a fallback if busy is still high.
        if (timer_expired) begin
          if (!sel_busy) issue   = 1'b1;
          else           state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        done_d        = 1'b1;
        save_active_d = 1'b0;
        load_active_d = 1'b0;
        state_d       = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      if (mode_load_q) begin
        rd_start_d = 1'b1;
        rd_addr_d  = sec_addr_q;
      end else begin
        wr_start_d = 1'b1;
        wr_addr_d  = sec_addr_q;
      end
      timer_start = 1'b1;
      timer_load  = TMO_LD;
      state_d     = ST_WAIT_HI;
    end

    // The error pulse is raised on entry to ERR so it lands exactly
    // TIMEOUT_CYCLES after the start pulse; ERR then returns to IDLE.
    if (fail) begin
      err_d         = 1'b1;
      save_active_d = 1'b0;
      load_active_d = 1'b0;
      state_d       = ST_ERR;
    end

    // New requests override a same-cycle grant clear, so they queue.
    if (save_req) begin
      save_pend_d = 1'b1;
      save_slot_d = slot_in;
    end
    if (load_req) begin
      load_pend_d = 1'b1;
      load_slot_d = slot_in;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      save_pend_q   <= 1'b0;
      load_pend_q   <= 1'b0;
      save_slot_q   <= '0;
      load_slot_q   <= '0;
      mode_load_q   <= 1'b0;
      sec_addr_q    <= '0;
      sector_idx_q  <= '0;
      wr_start_q    <= 1'b0;
      rd_start_q    <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      save_active_q <= 1'b0;
      load_active_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      save_pend_q   <= save_pend_d;
      load_pend_q   <= load_pend_d;
      save_slot_q   <= save_slot_d;
      load_slot_q   <= load_slot_d;
      mode_load_q   <= mode_load_d;
      sec_addr_q    <= sec_addr_d;
      sector_idx_q  <= sector_idx_d;
      wr_start_q    <= wr_start_d;
      rd_start_q    <= rd_start_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      save_active_q <= save_active_d;
      load_active_q <= load_active_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign wr_start_en = wr_start_q;
  assign wr_sec_addr = wr_addr_q;
  assign rd_start_en = rd_start_q;
  assign rd_sec_addr = rd_addr_q;
  assign save_active = save_active_q;
  assign load_active = load_active_q;
  assign sector_idx  = sector_idx_q;
  assign xfer_done   = done_q;
  assign xfer_err    = err_q;

endmodule

// File: tb/tb_sd_photo_scheduler.sv
// Directed + randomized bench for sd_photo_scheduler with a transfer-level
// reference model (expected transfer queue, sector addresses and pacing).
module tb_sd_photo_scheduler;

  localparam int BASE = 73744;
  localparam int SPP  = 4;
  localparam int GAP  = 3;
  localparam int TMO  = 20;

  logic        clk = 1'b0;
  logic        rst_n, save_req, load_req, wr_busy, rd_busy;
  logic [3:0]  slot_in;
  logic        wr_start_en, rd_start_en, save_active, load_active, xfer_done, xfer_err;
  logic [31:0] wr_sec_addr, rd_sec_addr;
  logic [10:0] sector_idx;

  always #5 clk = ~clk;

  sd_photo_scheduler #(
    .BASE_SEC         (32'(BASE)),
    .SECTORS_PER_PHOTO(SPP),
    .GAP_CYCLES       (GAP),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .save_req   (save_req),
    .load_req   (load_req),
    .slot_in    (slot_in),
    .wr_busy    (wr_busy),
    .rd_busy    (rd_busy),
    .wr_start_en(wr_start_en),
    .wr_sec_addr(wr_sec_addr),
    .rd_start_en(rd_start_en),
    .rd_sec_addr(rd_sec_addr),
    .save_active(save_active),
    .load_active(load_active),
    .sector_idx (sector_idx),
    .xfer_done  (xfer_done),
    .xfer_err   (xfer_err)
  );

  typedef struct { bit is_load; int slot; } xfer_t;

  int    n_compared = 0;
  int    n_mismatched = 0;
  int    cyc = 0;
  xfer_t exp_q[$];
  xfer_t cur;
  bit    have_cur = 0;
  int    nstarts = 0, nfalls = 0, last_start = 0, last_fall = 0, tot_starts = 0;
  int    bw_from = -1, bw_to = -1;
  bit    bw_load = 0, prev_b = 0, prev_active = 0;
  int    stuck_after = -1;
  int    n_done = 0, n_err = 0;
  logic [31:0] last_wr = '0, last_rd = '0;
  int    s, d, st0, k;
  bit    ld;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_compared++;
    assert (obs === exp_v) else begin
      n_mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic expect_xfer(input bit l, input int sl);
    xfer_t x;
    x.is_load = l;
    x.slot    = sl;
    exp_q.push_back(x);
  endtask

  task automatic req(input bit l, input int sl);
    slot_in = 4'(sl);
    if (l) load_req = 1'b1; else save_req = 1'b1;
    expect_xfer(l, sl);
  endtask

  task automatic observe();
    logic [31:0] ea;
    if (wr_start_en || rd_start_en) begin
      if (!have_cur) begin
        chk("start_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          have_cur = 1;
        end
        nstarts = 0;
        nfalls  = 0;
      end
      ea = 32'(BASE + cur.slot * SPP + nstarts);
      chk("start_port_rd", rd_start_en, cur.is_load);
      chk("start_port_wr", wr_start_en, !cur.is_load);
      chk("start_addr", cur.is_load ? rd_sec_addr : wr_sec_addr, ea);
      chk("idle_port_addr_hold", cur.is_load ? wr_sec_addr : rd_sec_addr,
          cur.is_load ? last_wr : last_rd);
      chk("start_active", {save_active, load_active}, cur.is_load ? 2'b01 : 2'b10);
      chk("start_sector_idx", sector_idx, nstarts);
      if (nstarts > 0) chk("gap_len", cyc - last_fall, GAP + 1);
      if (cur.is_load) last_rd = ea; else last_wr = ea;
      last_start = cyc;
      nstarts++;
      tot_starts++;
      if (stuck_after < 0 || nstarts <= stuck_after) begin
        bw_from = cyc + 2;
        bw_to   = cyc + 6;
        bw_load = cur.is_load;
      end
    end
    if (xfer_done) begin
      chk("done_sectors", nfalls, SPP);
      chk("done_latency", cyc - last_fall, 2);
      chk("done_active_low", {save_active, load_active}, 0);
      chk("done_active_prev", prev_active, 1);
      chk("done_sector_idx", sector_idx, SPP);
      have_cur = 0;
      n_done++;
    end
    if (xfer_err) begin
      chk("err_latency", cyc - last_start, TMO);
      chk("err_sector_idx", sector_idx, nfalls);
      chk("err_active_low", {save_active, load_active}, 0);
      have_cur = 0;
      n_err++;
    end
  endtask

  task automatic tick();
    bit b;
    @(posedge clk);
    #1;
    cyc++;
    save_req = 1'b0;
    load_req = 1'b0;
    observe();
    b = (cyc >= bw_from) && (cyc <= bw_to);
    wr_busy = b && !bw_load;
    rd_busy = b && bw_load;
    if (prev_b && !b) begin
      last_fall = cyc;
      nfalls++;
    end
    prev_b = b;
    prev_active = save_active | load_active;
  endtask

  task automatic wait_events(input int want_done, input int want_err, input int budget);
    int j = 0;
    while ((n_done < want_done || n_err < want_err) && j < budget) begin
      tick();
      j++;
    end
    chk("wait_events_in_budget", 64'(n_done >= want_done && n_err >= want_err), 1);
  endtask

  task automatic wait_start(input int budget);
    int j = 0;
    do begin
      tick();
      j++;
    end while (!(wr_start_en || rd_start_en) && j < budget);
    chk("start_in_budget", 64'(wr_start_en || rd_start_en), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_addr"}, wr_sec_addr, 0);
    chk({tag, "_rd_addr"}, rd_sec_addr, 0);
    chk({tag, "_ctrl"}, {wr_start_en, rd_start_en, save_active, load_active,
                         sector_idx, xfer_done, xfer_err}, 0);
  endtask

  initial begin
    rst_n = 1'b0; save_req = 1'b0; load_req = 1'b0; slot_in = '0;
    wr_busy = 1'b0; rd_busy = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Save slot 0: pend at t+1, active at t+2, first start at t+3.
    req(0, 0);
    tick();
    chk("pend_not_yet_active", save_active, 0);
    tick();
    chk("grant_save_active", save_active, 1);
    tick();
    chk("first_start_latency", wr_start_en, 1);
    wait_events(n_done + 1, n_err, 300);

    // Load slot 15; queue save 2 then load 3 while it runs: save wins.
    req(1, 15);
    tick();
    wait_start(50);
    req(0, 2);
    tick();
    req(1, 3);
    tick();
    wait_events(n_done + 3, n_err, 800);

    // Same-cycle save and load requests on one slot.
    s = $urandom_range(0, 15);
    req(0, s);
    req(1, s);
    tick();
    wait_events(n_done + 2, n_err, 600);

    // Busy stuck low from the 2nd start: timeout, then a normal transfer.
    stuck_after = 1;
    req(0, $urandom_range(0, 15));
    tick();
    wait_events(n_done, n_err + 1, 300);
    chk("err_idx_one", sector_idx, 1);
    chk("err_save_dropped", save_active, 0);
    stuck_after = -1;
    req(1, $urandom_range(0, 15));
    tick();
    wait_events(n_done + 1, n_err, 300);

    // Reset during the gap before the 3rd sector.
    s = $urandom_range(0, 15);
    req(0, s);
    tick();
    wait_start(50);
    k = 0;
    while (nfalls < 2 && k < 200) begin
      tick();
      k++;
    end
    chk("reached_second_fall", nfalls, 2);
    tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("midreset");
    have_cur = 0; last_wr = '0; last_rd = '0; bw_from = -1; bw_to = -1;
    rst_n = 1'b1;
    st0 = tot_starts;
    repeat (15) tick();
    chk("no_start_after_reset", tot_starts, st0);
    req(0, s);
    tick();
    wait_events(n_done + 1, n_err, 300);

    // Save request during an active save (slot 5) runs right after done.
    req(0, $urandom_range(0, 15));
    tick();
    wait_start(50);
    req(0, 5);
    tick();
    wait_events(n_done + 1, n_err, 300);
    d = cyc;
    wait_start(50);
    chk("queued_start_after_done", cyc - d, 2);
    wait_events(n_done + 1, n_err, 300);

    // Randomized sequence of single transfers.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      ld = 1'($urandom_range(0, 1));
      req(ld, $urandom_range(0, 15));
      tick();
      wait_events(n_done + 1, n_err, 300);
    end

    repeat (5) tick();
    chk("expected_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sd_photo_scheduler.md
# sd_photo_scheduler

Sequencer and arbiter sharing the single SD-card sector controller between the photo-capture (save) path and the photo-playback (load) path. Accepts save/load commands with a 4-bit photo slot and computes the slot's base sector. Issues paced per-sector start pulses to the SD write or read port and counts completed sectors. Drives the mode levels that gate the RAM address generators, and reports completion or timeout.

## Interface
- BASE_SEC, 73744: first SD sector of slot 0.
- SECTORS_PER_PHOTO, 1200: sectors per photo; slot n starts at BASE_SEC + n*SECTORS_PER_PHOTO.
- GAP_CYCLES, 50000: idle clocks between the end of one sector and the next start pulse.
- TIMEOUT_CYCLES, 5000000: maximum clocks from a start pulse to that sector's busy falling edge.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- save_req  in  1  one-cycle pulse: save current frame to slot_in.
- load_req  in  1  one-cycle pulse: load photo from slot_in.
- slot_in  in  4  slot number, sampled with either request.
- wr_busy  in  1  SD write controller busy.
- rd_busy  in  1  SD read controller busy.
- wr_start_en  out  1  one-cycle sector write start.
- wr_sec_addr  out  32  sector address for the write.
- rd_start_en  out  1  one-cycle sector read start.
- rd_sec_addr  out  32  sector address for the read.
- save_active  out  1  level, high for the whole save transfer.
- load_active  out  1  level, high for the whole load transfer.
- sector_idx  out  11  sectors completed in the current transfer.
- xfer_done  out  1  one-cycle pulse when the last sector completes.
- xfer_err  out  1  one-cycle pulse on timeout.

## Operation
- Pending flags: save_req sets save_pend and captures save_slot; load_req sets load_pend and captures load_slot. The flags are one-deep. A repeat request while pending overwrites the slot. A request during an active transfer of the same kind is queued, not merged.
- Arbitration happens in IDLE only. If both flags are set, save wins and the load stays pending. The granted flag clears on grant.
- On grant: sec_addr is set to BASE_SEC + slot*SECTORS_PER_PHOTO (32-bit, no overflow check), sector_idx is set to 0, and the matching *_active level is raised.
- States:
  - IDLE: wait for a pending flag.
  - ISSUE: wait for the selected busy to be low, then pulse *_start_en for 1 cycle with *_sec_addr valid.
  - WAIT_HI: selected busy seen high -> WAIT_LO.
  - WAIT_LO: busy low -> sector_idx+1, sec_addr+1. If sector_idx reaches SECTORS_PER_PHOTO -> DONE, else -> GAP.
  - GAP: count GAP_CYCLES -> ISSUE.
  - DONE: pulse xfer_done, drop *_active -> IDLE.
  - ERR: pulse xfer_err, drop *_active, keep sector_idx -> IDLE.
- Timeout: a counter is cleared at each start pulse and runs through WAIT_HI and WAIT_LO. Reaching TIMEOUT_CYCLES -> ERR.
- The unused port's start_en stays 0; its sec_addr holds its last value.

## Timing
- Reset (rst_n low at a clk edge): all outputs 0, state IDLE, pending flags cleared, counters 0. Applies mid-transfer too: the SD controller finishes its sector, nothing further is issued.
- Request pulse at cycle t -> pend set at t+1 -> grant and *_active high at t+2 -> earliest start pulse at t+3.
- Next start pulse comes exactly GAP_CYCLES+1 clocks after the busy falling edge, provided busy is still low.
- xfer_done and the *_active falling edge occur on the same cycle, 2 clocks after the last busy falling edge.
- A request arriving in the same cycle as DONE is latched and is granted in the following IDLE cycle.
- sector_idx saturates at SECTORS_PER_PHOTO; it never wraps within a transfer.

## Structure
- Shared package sd_photo_pkg holds: the state enum, the BASE_SEC and SECTORS_PER_PHOTO constants, and a slot-to-sector function (shift-add for 1200 = 1024+128+32+16).
- One natural sub-module, sd_pace_timer: a loadable down-counter used for both GAP and timeout, with a start/expired interface.

## Test plan
- Bench parameters for all scenarios: SECTORS_PER_PHOTO=4, GAP_CYCLES=3, TIMEOUT_CYCLES=20; the busy model goes high 2 cycles after start and stays high 5 cycles.
- Save slot 0 -> 4 wr_start_en pulses at 73744..73747; xfer_done after the 4th busy fall; rd_start_en never high.
- Load slot 15 -> rd_sec_addr 73744+60 = 73804..73807; load_active high throughout, low with xfer_done.
- save_req and load_req in the same cycle (slots 2 and 3) -> save of 73752..73755 runs first, then load of 73756..73759 with no further request.
- Busy model stuck low after the 2nd start -> xfer_err 20 cycles after that start; sector_idx=1; save_active drops; the next request proceeds normally.
- rst_n low during the 3rd sector's GAP -> all outputs 0 next cycle; no further start pulses; a new save_req restarts from the slot base.
- save_req during an active save (new slot 5) -> runs immediately after xfer_done at 73764..73767.
